qam_tx_scheduler: RTL and testbench
===================================

// Module: qam_tx_scheduler
// PURPOSE
//  Sequences 65-bit QAM samples from combiner into uart_transmitter_65bit; replaces free-running pulse_generator.
//  Gates capture until CORDIC and both FIR outputs are valid, then decimates combined_output.
//  Buffers captured words in a small FIFO and issues one tx_start per word, spacing frames by a fixed UART frame time.
//  Sits between combiner_0 and uart_transmitter_65bit_0 in my_design.
// PARAMETERS
//  DATA_W           65    sample/UART word width
//  FIFO_DEPTH       4     capture buffer entries (power of 2, >=2)
//  DECIM            1024  clk cycles between captures (>=2)
//  WARM_CYCLES      8     consecutive all-valid cycles before capture starts (>=1)
//  TX_FRAME_CYCLES  7150  clk cycles one UART word occupies (>=2)
//  GAP_CYCLES       16    idle cycles after each frame (>=0)
// PORTS
//  clk           in   1        system clock
//  reset         in   1        asynchronous active-high reset
//  enable        in   1        1 = capture allowed
//  dout_valid    in   1        CORECORDIC DOUT_VALID
//  firo_valid_i  in   1        I-path FIR FIRO_VALID
//  firo_valid_q  in   1        Q-path FIR FIRO_VALID
//  combined_in   in   DATA_W   combiner combined_output
//  tx_start      out  1        one-cycle start pulse to UART
//  tx_data       out  DATA_W   word to UART full_bus, stable from tx_start through end of frame
//  busy          out  1        1 in LAUNCH/WAIT/GAP
//  fifo_level    out  clog2(FIFO_DEPTH)+1  current occupancy
//  overflow      out  1        sticky: a capture was dropped
//  drop_count    out  8        dropped captures, saturates at 255
// BEHAVIOUR
//  Clock is clk; reset is asynchronous and active-high. On reset: all outputs 0, FIFO empty, FSM=IDLE, counters 0.
//  warm_ok: set after WARM_CYCLES consecutive cycles with enable&dout_valid&firo_valid_i&firo_valid_q.
//    Cleared the same cycle any of these is low; warm counter restarts.
//  Decimation counter: held at 0 while !warm_ok; increments when warm_ok; wraps at DECIM-1.
//    Capture (push combined_in) in the cycle the counter = DECIM-1.
//  Push when full: if a pop occurs in the same cycle, the push is accepted.
//    Otherwise the word is dropped: overflow<=1, drop_count+=1 (saturating).
//  FSM (registered):
//    IDLE   : FIFO non-empty -> LAUNCH.
//    LAUNCH : 1 cycle; pop FIFO head into tx_data reg; tx_start=1; frame counter<=0 -> WAIT.
//    WAIT   : count to TX_FRAME_CYCLES-1 -> GAP (or IDLE if GAP_CYCLES=0).
//    GAP    : count to GAP_CYCLES-1 -> IDLE.
//  tx_start is high only in LAUNCH; never two pulses closer than TX_FRAME_CYCLES+GAP_CYCLES+1.
//  Latency: push at cycle N with FSM in IDLE -> LAUNCH (tx_start=1) at N+1 -> tx_data valid from N+1.
//  Valid/enable drop mid-run: capture stops immediately; FIFO contents and in-flight frame still drain normally.
//  Reset mid-frame: tx_start/busy fall asynchronously; tx_data cleared; no partial-frame recovery.
//  Simultaneous push into empty FIFO and IDLE: word launches next cycle (no bypass path).
//  Occupancy math uses DEPTH+1 state pointers; fifo_level = wr_ptr - rd_ptr, no wrap error at full.
// STRUCTURE
//  qam_pkg: FSM state typedef (IDLE, LAUNCH, WAIT, GAP), DATA_W=65 constant, drop-count width.
//  Sub-module: qam_sample_fifo (sync FIFO, DATA_W x FIFO_DEPTH, push/pop/full/empty/level).
//  Top keeps warm-up logic, decimator, FSM, frame/gap counters, overflow stats.
// TESTING (DECIM=4, WARM_CYCLES=3, TX_FRAME_CYCLES=10, GAP_CYCLES=2, FIFO_DEPTH=4)
//  Reset asserted mid-WAIT -> tx_start=0, busy=0, fifo_level=0, drop_count=0 immediately, before next clk edge.
//  All valids and enable rise at cycle 0 -> warm_ok at cycle 3; first push at cycle 6; tx_start at cycle 7 only.
//  combined_in = cycle-count ramp -> each tx_data equals the value at its push cycle.
//    tx_data holds for 10 cycles; tx_start pulses every 13 cycles.
//  Steady run for 200 cycles -> FIFO saturates at 4; overflow=1.
//    drop_count = captures - launches - 4; no tx_start spacing < 13.
//  firo_valid_q low for 1 cycle at cycle 20 -> no push until 3 cycles of valid + 4 decimation cycles.
//    Queued words still transmit.
//  Force 300 drops (GAP_CYCLES=1000) -> drop_count sticks at 255; overflow stays 1 until reset.

Source files
------------

// File: rtl/qam_pkg.sv
// qam_pkg: shared state type and constants for the QAM transmit scheduler
package qam_pkg;
    localparam int QAM_DATA_W = 65;
    localparam int DROP_W     = 8;
    typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, GAP} tx_state_t;
endpackage

// File: rtl/qam_sample_fifo.sv
// qam_sample_fifo: synchronous capture FIFO with DEPTH+1 state pointers for exact occupancy
module qam_sample_fifo
    import qam_pkg::*;
#(
    parameter int DATA_W = QAM_DATA_W,
    parameter int DEPTH  = 4
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic [DATA_W-1:0]        i_data,
    output logic [DATA_W-1:0]        o_head,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_level
);
    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [AW:0]       r_wr_ptr, r_rd_ptr;
    logic              w_push, w_pop;

    assign o_level = r_wr_ptr - r_rd_ptr;
    assign o_full  = o_level == (AW+1)'(DEPTH);
    assign o_empty = o_level == '0;
    assign w_pop   = i_pop && !o_empty;
    // A push into a full FIFO is still taken when the head leaves in the same cycle
    assign w_push  = i_push && (!o_full || w_pop);
    assign o_head  = r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
    end
endmodule

// File: rtl/qam_tx_scheduler.sv
// qam_tx_scheduler: gated, decimated capture of combiner samples, paced out to the 65-bit UART
module qam_tx_scheduler
    import qam_pkg::*;
#(
    parameter int DATA_W          = QAM_DATA_W,
    parameter int FIFO_DEPTH      = 4,
    parameter int DECIM           = 1024,
    parameter int WARM_CYCLES     = 8,
    parameter int TX_FRAME_CYCLES = 7150,
    parameter int GAP_CYCLES      = 16
) (
    input  logic                          i_clk,
    input  logic                          i_reset,
    input  logic                          i_enable,
    input  logic                          i_dout_valid,
    input  logic                          i_firo_valid_i,
    input  logic                          i_firo_valid_q,
    input  logic [DATA_W-1:0]             i_combined_in,
    output logic                          o_tx_start,
    output logic [DATA_W-1:0]             o_tx_data,
    output logic                          o_busy,
    output logic [$clog2(FIFO_DEPTH):0]   o_fifo_level,
    output logic                          o_overflow,
    output logic [DROP_W-1:0]             o_drop_count
);
    localparam int WW      = $clog2(WARM_CYCLES + 1);
    localparam int DW      = $clog2(DECIM);
    localparam int CNT_MAX = TX_FRAME_CYCLES > GAP_CYCLES ? TX_FRAME_CYCLES : GAP_CYCLES;
    localparam int CW      = $clog2(CNT_MAX);

    tx_state_t         r_state, w_next;
    logic [WW-1:0]     r_warm_cnt;
    logic [DW-1:0]     r_dec_cnt;
    logic [CW-1:0]     r_cnt;
    logic [DATA_W-1:0] r_tx_data, w_head;
    logic              r_overflow;
    logic [DROP_W-1:0] r_drop_count;
    logic              w_all_valid, w_warm_ok, w_push, w_pop, w_full, w_empty;
    logic              w_have, w_frame_end, w_gap_end;

    assign w_all_valid = i_enable & i_dout_valid & i_firo_valid_i & i_firo_valid_q;
    // warm_ok drops combinationally so capture stops in the very cycle a valid falls
    assign w_warm_ok   = w_all_valid && r_warm_cnt == WW'(WARM_CYCLES);
    assign w_push      = w_warm_ok && r_dec_cnt == DW'(DECIM - 1);
    assign w_pop       = r_state == LAUNCH;
    assign w_have      = !w_empty || w_push;
    assign w_frame_end = r_cnt == CW'(TX_FRAME_CYCLES - 1);
    assign w_gap_end   = r_cnt == CW'(GAP_CYCLES - 1);

    qam_sample_fifo #(.DATA_W(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_data  (i_combined_in),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_level (o_fifo_level)
    );

    // End of a frame's spacing goes straight to LAUNCH when work is queued,
    // so back-to-back starts are exactly TX_FRAME_CYCLES+GAP_CYCLES+1 apart
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = w_have ? LAUNCH : IDLE;
            LAUNCH:  w_next = WAIT;
            WAIT:    if (w_frame_end) w_next = GAP_CYCLES == 0 ? (w_have ? LAUNCH : IDLE) : GAP;
            GAP:     if (w_gap_end) w_next = w_have ? LAUNCH : IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state      <= IDLE;
            r_warm_cnt   <= '0;
            r_dec_cnt    <= '0;
            r_cnt        <= '0;
            r_tx_data    <= '0;
            r_overflow   <= 1'b0;
            r_drop_count <= '0;
        end else begin
            r_state    <= w_next;
            r_warm_cnt <= !w_all_valid ? '0 : w_warm_ok ? r_warm_cnt : r_warm_cnt + WW'(1);
            r_dec_cnt  <= (w_warm_ok && !w_push) ? r_dec_cnt + DW'(1) : '0;
            r_cnt      <= (w_pop || (r_state == WAIT && w_frame_end)) ? '0 : r_cnt + CW'(1);
            if (w_pop) r_tx_data <= w_head;
            if (w_push && w_full && !w_pop) begin
                r_overflow <= 1'b1;
                if (r_drop_count != '1) r_drop_count <= r_drop_count + DROP_W'(1);
            end
        end
    end

    assign o_tx_start   = r_state == LAUNCH;
    assign o_busy       = r_state != IDLE;
    assign o_tx_data    = o_tx_start ? w_head : r_tx_data;
    assign o_overflow   = r_overflow;
    assign o_drop_count = r_drop_count;
endmodule

// File: tb/tb_qam_tx_scheduler.sv
// tb_qam_tx_scheduler: scoreboard bench; ramp input so every launched word names its capture cycle
`timescale 1ns/1ps
module tb_qam_tx_scheduler;
    localparam int W = 65;

    logic         clk = 1'b0, rst_a = 1'b0, rst_b = 1'b0;
    logic         en_a = 1'b0, en_b = 1'b0, dv = 1'b0, fvi = 1'b0, fvq = 1'b0;
    logic [W-1:0] din = '0;
    logic         start_a, start_b, busy_a, busy_b, ovf_a, ovf_b;
    logic [W-1:0] data_a, data_b;
    logic [2:0]   lvl_a, lvl_b;
    logic [7:0]   drop_a, drop_b;
    int           n_chk = 0, n_pass = 0, cyc = -1;
    logic [W-1:0] sb [$];

    always #5 clk = ~clk;

    qam_tx_scheduler #(.DATA_W(W), .FIFO_DEPTH(4), .DECIM(4), .WARM_CYCLES(3),
                       .TX_FRAME_CYCLES(10), .GAP_CYCLES(2)) dut_a (
        .i_clk(clk), .i_reset(rst_a), .i_enable(en_a), .i_dout_valid(dv),
        .i_firo_valid_i(fvi), .i_firo_valid_q(fvq), .i_combined_in(din),
        .o_tx_start(start_a), .o_tx_data(data_a), .o_busy(busy_a),
        .o_fifo_level(lvl_a), .o_overflow(ovf_a), .o_drop_count(drop_a)
    );

    qam_tx_scheduler #(.DATA_W(W), .FIFO_DEPTH(4), .DECIM(4), .WARM_CYCLES(3),
                       .TX_FRAME_CYCLES(10), .GAP_CYCLES(1000)) dut_b (
        .i_clk(clk), .i_reset(rst_b), .i_enable(en_b), .i_dout_valid(dv),
        .i_firo_valid_i(fvi), .i_firo_valid_q(fvq), .i_combined_in(din),
        .o_tx_start(start_b), .o_tx_data(data_b), .o_busy(busy_b),
        .o_fifo_level(lvl_b), .o_overflow(ovf_b), .o_drop_count(drop_b)
    );

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
    endtask

    logic [W-1:0] hold_val = '0;
    int           hold_left = 0, last_start = -1;

    always @(negedge clk) begin
        if (!rst_a && start_a === 1'b1) begin
            if (sb.size() == 0) chk("start_unexpected", W'(start_a), W'(0));
            else begin
                hold_val = sb.pop_front();
                chk("tx_data", data_a, hold_val);
            end
            if (last_start >= 0) chk("start_spacing", W'(cyc - last_start), W'(13));
            last_start = cyc;
            hold_left  = 10;
        end else if (hold_left > 0) begin
            chk("tx_hold", data_a, hold_val);
            hold_left--;
        end
    end

    initial begin
        int  lvl, drops;
        bit  push, pop;
        lvl   = 0;
        drops = 0;
        #1 rst_a = 1'b1; rst_b = 1'b1;
        #2;
        chk("rst_start_a", W'(start_a), W'(0));
        chk("rst_busy_a",  W'(busy_a),  W'(0));
        chk("rst_data_a",  data_a,      W'(0));
        chk("rst_level_a", W'(lvl_a),   W'(0));
        chk("rst_ovf_a",   W'(ovf_a),   W'(0));
        chk("rst_drop_a",  W'(drop_a),  W'(0));
        chk("rst_busy_b",  W'(busy_b),  W'(0));
        @(posedge clk); #1 rst_a = 1'b0; rst_b = 1'b0;
        @(posedge clk); #1;
        for (int c = 0; c <= 2040; c++) begin
            cyc  = c;
            en_a = c < 200;
            en_b = 1'b1;
            dv   = 1'b1;
            fvi  = 1'b1;
            fvq  = c != 20;
            din  = W'(c);
            @(negedge clk);
            push = (c == 6 || c == 10 || c == 14 || c == 18) || (c >= 27 && c < 200 && (c - 27) % 4 == 0);
            pop  = c >= 7 && (c - 7) % 13 == 0 && lvl > 0;
            chk("level_a", W'(lvl_a), W'(lvl));
            chk("start_a", W'(start_a), W'(pop));
            if (push) begin
                if (lvl < 4 || pop) begin
                    sb.push_back(W'(c));
                    lvl++;
                end else drops++;
            end
            if (pop) lvl--;
            if (c == 8 || c == 19) chk("busy_a", W'(busy_a), W'(1));
            if (c == 200) begin
                chk("drop_a_200",  W'(drop_a), W'(29));
                chk("ovf_a_200",   W'(ovf_a),  W'(1));
                chk("drop_a_model", W'(drop_a), W'(drops));
            end
            if (c == 7)    begin chk("start_b_7", W'(start_b), W'(1)); chk("data_b_7", data_b, W'(6)); end
            if (c == 8)    chk("busy_b_8", W'(busy_b), W'(1));
            if (c == 200)  begin chk("drop_b_200", W'(drop_b), W'(43)); chk("level_b_200", W'(lvl_b), W'(4)); end
            if (c == 1017) chk("start_b_1017", W'(start_b), W'(0));
            if (c == 1018) begin chk("start_b_1018", W'(start_b), W'(1)); chk("data_b_1018", data_b, W'(10)); end
            if (c == 2029) begin chk("start_b_2029", W'(start_b), W'(1)); chk("data_b_2029", data_b, W'(14)); end
            if (c == 2032) begin chk("drop_b_sat", W'(drop_b), W'(255)); chk("ovf_b_sticky", W'(ovf_b), W'(1)); end
            if (c == 2033) begin
                chk("busy_b_wait", W'(busy_b), W'(1));
                #2 rst_b = 1'b1;
                #1;
                chk("arst_start_b", W'(start_b), W'(0));
                chk("arst_busy_b",  W'(busy_b),  W'(0));
                chk("arst_level_b", W'(lvl_b),   W'(0));
                chk("arst_drop_b",  W'(drop_b),  W'(0));
                chk("arst_ovf_b",   W'(ovf_b),   W'(0));
                chk("arst_data_b",  data_b,      W'(0));
            end
            @(posedge clk); #1;
        end
        chk("end_busy_a",  W'(busy_a),    W'(0));
        chk("end_drop_a",  W'(drop_a),    W'(29));
        chk("end_ovf_a",   W'(ovf_a),     W'(1));
        chk("sb_drained",  W'(sb.size()), W'(0));
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
